data_deserializer: RTL

DATA_DESERIALIZER -- requirements
Module: data_deserializer

---
 rtl/data_deserializer_pkg.sv | 19 +
 rtl/data_deserializer_sat_counter.sv | 24 ++
 rtl/data_deserializer.sv | 107 ++++++++++
 3 files changed

// File: rtl/data_deserializer_pkg.sv
// Frame constants and FSM encoding shared by the ADC data serializer and deserializer.
// Frame: start(1), channel, DATA_WIDTH payload bits MSB first, stop(0); one bit per clock.
package data_deserializer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam logic CH_LOWER  = 1'b0;
    localparam logic CH_UPPER  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHANNEL = 2'd1,
        ST_DATA    = 2'd2,
        ST_STOP    = 2'd3
    } state_t;

endpackage

// File: rtl/data_deserializer_sat_counter.sv
// Saturating up-counter: increments on i_inc, sticks at all-ones, never wraps.
// Single-cycle update; synchronous active-high reset clears it.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/data_deserializer.sv
// Serial ADC frame deserializer: recovers channel-tagged payloads, flags bad stop bits.
// Outputs and one-cycle pulses appear in the cycle after the stop bit is sampled; no backpressure.
module data_deserializer
    import data_deserializer_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int ERR_COUNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_bit,
    output logic [DATA_WIDTH-1:0]      lower_adc_data,
    output logic [DATA_WIDTH-1:0]      upper_adc_data,
    output logic                       lower_adc_data_enable,
    output logic                       upper_adc_data_enable,
    output logic                       frame_error,
    output logic [ERR_COUNT_WIDTH-1:0] error_count
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic                    r_channel;
    logic [DATA_WIDTH-1:0]   r_lower;
    logic [DATA_WIDTH-1:0]   r_upper;
    logic                    r_lower_en;
    logic                    r_upper_en;
    logic                    r_frame_err;
    logic                    w_stop_ok;
    logic                    w_stop_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (in_bit == START_BIT) w_next_state = ST_CHANNEL;
            ST_CHANNEL: w_next_state = ST_DATA;
            ST_DATA:    if (r_bit_cnt == LAST_BIT) w_next_state = ST_STOP;
            ST_STOP:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    assign w_stop_ok  = (r_state == ST_STOP) && (in_bit == STOP_BIT);
    assign w_stop_bad = (r_state == ST_STOP) && (in_bit != STOP_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_channel   <= 1'b0;
            r_lower     <= '0;
            r_upper     <= '0;
            r_lower_en  <= 1'b0;
            r_upper_en  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_lower_en  <= 1'b0;
            r_upper_en  <= 1'b0;
            r_frame_err <= w_stop_bad;
            if (r_state == ST_CHANNEL) begin
                r_channel <= in_bit;
                r_bit_cnt <= '0;
            end
            if (r_state == ST_DATA) begin
                r_shift   <= {r_shift[DATA_WIDTH-2:0], in_bit};
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            // Only a clean stop bit commits the payload; the other channel keeps its value.
            if (w_stop_ok && (r_channel == CH_LOWER)) begin
                r_lower    <= r_shift;
                r_lower_en <= 1'b1;
            end
            if (w_stop_ok && (r_channel == CH_UPPER)) begin
                r_upper    <= r_shift;
                r_upper_en <= 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (ERR_COUNT_WIDTH)
    ) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stop_bad),
        .o_count (error_count)
    );

    assign lower_adc_data        = r_lower;
    assign upper_adc_data        = r_upper;
    assign lower_adc_data_enable = r_lower_en;
    assign upper_adc_data_enable = r_upper_en;
    assign frame_error           = r_frame_err;

endmodule
